// File: rtl/video_timing_meas.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_meas
// Brief    : Measures h/v timing of an hs/vs/de stream and publishes an atomic
//            result set at every frame start. Optional macro: VTM_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_meas #(
  parameter int CW           = 12,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          hs,
  input  logic          vs,
  input  logic          de,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] vs_width,
  output logic [15:0]   frame_cnt,
  output logic          valid,
  output logic          changed
);

  localparam logic [CW-1:0] c_one = CW'(1);
  localparam logic [CW-1:0] c_max = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == c_max) ? v : v + c_one;
  endfunction

  logic          r_hs_q, r_vs_q, r_de_q;
  logic          r_hs_a_d, r_vs_a_d;
  logic          w_hs_a, w_vs_a;
  logic          w_line_start, w_frame_start, w_hs_fall;
  logic [CW-1:0] r_h_cnt, r_hs_cnt, r_de_cnt;
  logic [CW-1:0] r_ht_sh, r_hsw_sh, r_hact_sh;
  logic [CW-1:0] r_v_cnt, r_vs_cnt, r_vact_cnt;
  logic [CW-1:0] w_pub_ht, w_pub_hsw, w_pub_hact;
  logic [CW-1:0] w_pub_vt, w_pub_vsw, w_pub_vact;
  logic          w_diff;
  logic          w_wd_fire;
  logic          r_pub_seen;

  // Idle reset level of the input stage is the inactive sync level, so no
  // spurious edge is seen on the first clock after reset release.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_q   <= SYNC_ACT_LOW;
      r_vs_q   <= SYNC_ACT_LOW;
      r_de_q   <= 1'b0;
      r_hs_a_d <= 1'b0;
      r_vs_a_d <= 1'b0;
    end else begin
      r_hs_q   <= hs;
      r_vs_q   <= vs;
      r_de_q   <= de;
      r_hs_a_d <= w_hs_a;
      r_vs_a_d <= w_vs_a;
    end
  end

  assign w_hs_a        = r_hs_q ^ SYNC_ACT_LOW;
  assign w_vs_a        = r_vs_q ^ SYNC_ACT_LOW;
  assign w_line_start  = w_hs_a & ~r_hs_a_d;
  assign w_hs_fall     = ~w_hs_a & r_hs_a_d;
  assign w_frame_start = w_vs_a & ~r_vs_a_d;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt   <= '0;
      r_hs_cnt  <= '0;
      r_de_cnt  <= '0;
      r_ht_sh   <= '0;
      r_hsw_sh  <= '0;
      r_hact_sh <= '0;
    end else begin
      if (w_line_start) begin
        r_h_cnt  <= c_one;
        r_hs_cnt <= c_one;
        r_de_cnt <= r_de_q ? c_one : '0;
        r_ht_sh  <= r_h_cnt;
      end else begin
        r_h_cnt <= sat_inc(r_h_cnt);
        if (w_hs_a) r_hs_cnt <= sat_inc(r_hs_cnt);
        if (r_de_q) r_de_cnt <= sat_inc(r_de_cnt);
      end
      if (w_hs_fall) r_hsw_sh <= r_hs_cnt;
      if (w_frame_start) r_hact_sh <= '0;
      else if (w_line_start && (r_de_cnt > r_hact_sh)) r_hact_sh <= r_de_cnt;
    end
  end

  // A line start coinciding with a frame start is line 1 of the new frame.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_v_cnt    <= '0;
      r_vs_cnt   <= '0;
      r_vact_cnt <= '0;
    end else if (w_frame_start) begin
      r_v_cnt    <= w_line_start ? c_one : '0;
      r_vs_cnt   <= w_line_start ? c_one : '0;
      r_vact_cnt <= '0;
    end else if (w_line_start) begin
      r_v_cnt <= sat_inc(r_v_cnt);
      if (w_vs_a) r_vs_cnt <= sat_inc(r_vs_cnt);
      if (r_de_cnt != '0) r_vact_cnt <= sat_inc(r_vact_cnt);
    end
  end

  // Values published at a frame start fold in the line that ends on that cycle.
  assign w_pub_ht   = w_line_start ? r_h_cnt : r_ht_sh;
  assign w_pub_hsw  = w_hs_fall ? r_hs_cnt : r_hsw_sh;
  assign w_pub_hact = (w_line_start && (r_de_cnt > r_hact_sh)) ? r_de_cnt : r_hact_sh;
  assign w_pub_vt   = r_v_cnt;
  assign w_pub_vsw  = r_vs_cnt;
  assign w_pub_vact = (w_line_start && (r_de_cnt != '0)) ? sat_inc(r_vact_cnt) : r_vact_cnt;

  assign w_diff = (w_pub_ht   != h_total)  | (w_pub_hsw  != hs_width) |
                  (w_pub_hact != h_active) | (w_pub_vt   != v_total)  |
                  (w_pub_vact != v_active) | (w_pub_vsw  != vs_width);

`ifdef VTM_WATCHDOG_EN
  logic [CW-1:0] r_wd_cnt;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)          r_wd_cnt <= '0;
    else if (w_line_start) r_wd_cnt <= '0;
    else                   r_wd_cnt <= sat_inc(r_wd_cnt);
  end

  // Fires once, on the clock the counter reaches full scale.
  assign w_wd_fire = !w_line_start && (r_wd_cnt == (c_max - c_one));
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_total    <= '0;
      h_active   <= '0;
      hs_width   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      vs_width   <= '0;
      frame_cnt  <= '0;
      valid      <= 1'b0;
      changed    <= 1'b0;
      r_pub_seen <= 1'b0;
    end else if (w_frame_start) begin
      h_total    <= w_pub_ht;
      h_active   <= w_pub_hact;
      hs_width   <= w_pub_hsw;
      v_total    <= w_pub_vt;
      v_active   <= w_pub_vact;
      vs_width   <= w_pub_vsw;
      frame_cnt  <= frame_cnt + 16'd1;
      valid      <= r_pub_seen & ~w_diff;
      changed    <= r_pub_seen & w_diff;
      r_pub_seen <= 1'b1;
    end else if (w_wd_fire) begin
      h_total <= '0;
      v_total <= '0;
      valid   <= 1'b0;
      changed <= 1'b1;
    end else begin
      changed <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/video_timing_meas.md
VIDEO_TIMING_MEAS -- requirements
Module: video_timing_meas

Interface
REQ-001 SHALL have parameter: CW, 12, width of all measurement counters and outputs.
REQ-002 SHALL have parameter: SYNC_ACT_LOW, 1, 1 = hs/vs asserted low, 0 = asserted high.
REQ-003 SHALL have port: pclk  input  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: hs  input  1  horizontal sync from video generator.
REQ-006 SHALL have port: vs  input  1  vertical sync from video generator.
REQ-007 SHALL have port: de  input  1  display enable (active pixel) from video generator.
REQ-008 SHALL have ports: h_total, h_active, hs_width  output  CW  clocks per line, DE clocks per line, hsync clocks.
REQ-009 SHALL have ports: v_total, v_active, vs_width  output  CW  lines per frame, lines containing DE, vsync lines.
REQ-010 SHALL have port: frame_cnt  output  16  count of published frames.
REQ-011 SHALL have port: valid  output  1  last two published frames were identical.
REQ-012 SHALL have port: changed  output  1  one-cycle pulse when a publish differs from the previous one.

Function
REQ-013 SHALL register hs, vs and de in one input stage, then detect edges on the registered values. hs_a/vs_a = input XOR SYNC_ACT_LOW.
REQ-014 SHALL define a line start as the hs_a rising edge (leading edge) and a frame start as the vs_a rising edge.
REQ-015 SHALL count clocks between consecutive line starts. This count SHALL be latched into a shadow h_total at each line start, and the counter SHALL restart at 1.
REQ-016 SHALL count clocks while hs_a is high and latch the count into a shadow hs_width on the hs_a falling edge.
REQ-017 SHALL count de-high clocks per line, latch the count into a shadow h_active at line start, then clear it. The shadow SHALL hold the maximum over the frame.
REQ-018 SHALL count line starts between frame starts (shadow v_total), line starts while vs_a is high (shadow vs_width), and lines with at least one de clock (shadow v_active).
REQ-019 SHALL treat a line start coinciding with a frame start as line 1 of the new frame.
REQ-020 SHALL copy all six shadows to the outputs atomically at frame start. Outputs SHALL update exactly 2 pclk after the input vs transition edge. frame_cnt SHALL increment on the same cycle and wrap 0xFFFF->0.
REQ-021 SHALL saturate all counters at 2^CW-1 with no wrap.
REQ-022 SHALL set valid at publish iff all six new values equal the previously published values, and clear valid otherwise.
REQ-023 SHALL pulse changed for one cycle at a publish where any value differs from the previous publish. changed SHALL stay 0 on the first publish after reset.
REQ-024 SHALL hold the outputs stable between publishes and never show a partially updated set.

Reset
REQ-025 SHALL, while reset_n is low, force all outputs, counters and shadows to 0 and clear valid, changed and the first-publish flag.
REQ-026 SHALL discard any partial frame in progress when reset asserts mid-frame. The first publish after release SHALL have valid=0 and changed=0.

Configuration
REQ-027 SHALL, with VTM_WATCHDOG_EN defined, count clocks since the last line start. If the count reaches 2^CW-1 (no hsync), it SHALL clear valid, zero h_total and v_total outputs, and pulse changed once. Normal operation SHALL resume at the next frame start.
REQ-028 SHALL, without VTM_WATCHDOG_EN, omit the watchdog. Outputs SHALL then hold their last published values indefinitely when sync stops.

Verification
REQ-029 SHALL test the nominal frame: 384-clk lines, hs low 29 clk, de 256 clk on lines 17..240, 264 lines, vs low 3 lines. Required response: after the 2nd frame start h_total=384, hs_width=29, h_active=256, v_total=264, v_active=224, vs_width=3; valid=1 from the 3rd publish.
REQ-030 SHALL test a mid-run change of line length 384->400. Required response: changed pulses once at the next publish, valid=0 for that publish, valid=1 one frame later with h_total=400.
REQ-031 SHALL test a coincident hs and vs leading edge. Required response: v_total unchanged at 264, with no off-by-one.
REQ-032 SHALL test reset_n pulsed low at line 100. Required response: outputs 0 immediately, first publish after release has valid=0 and changed=0, frame_cnt=1.
REQ-033 SHALL test hs held inactive for 5000 clk with CW=12. Required response: with VTM_WATCHDOG_EN, valid=0, h_total=0 and changed pulses at clock 4095; without it, outputs are unchanged.
REQ-034 SHALL test SYNC_ACT_LOW=0 with inverted stimulus from REQ-029. Required response: identical measurements.
